// File: rtl/seq_div_if.sv
// seq_div_if: request/result bundle between the ALU control FSM (master)
// and the sequential divider (slave).
interface seq_div_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, overflow
  );
endinterface

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, one quotient bit per clock.
// IDLE -> RUN (WIDTH iterations) -> [SIGN] -> FIN (done pulse) -> IDLE.
// Divide-by-zero skips RUN and goes straight to FIN with overflow set.
// Optional feature macro: SEQ_DIV_SIGNED_EN (two's complement operands,
// truncating division, adds the SIGN state and MIN/-1 overflow).
module seq_div #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  seq_div_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_W     = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef SEQ_DIV_SIGNED_EN
    SIGN = 2'd2,
`endif
    FIN  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [WIDTH-1:0] rem_r;      // partial remainder (always < divisor between steps)
  logic [WIDTH-1:0] q_r;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] div_r;      // captured divisor (magnitude when signed)
  logic [CNT_W-1:0] cnt_r;      // iterations left, WIDTH-1 down to 0

  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;

  logic             special_s;  // start that bypasses RUN
  logic [WIDTH:0]   r_shift_s;  // WIDTH+1-bit shifted partial remainder
  logic [WIDTH:0]   r_diff_s;
  logic             r_ge_s;
  logic [WIDTH-1:0] r_next_s;
  logic [WIDTH-1:0] q_next_s;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q_r;                // operand signs differ
  logic neg_r_r;                // dividend negative

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      mag = -v;
    end else begin
      mag = v;
    end
  endfunction
`endif

  // Detect starts that go directly to FIN (divide-by-zero, signed MIN/-1).
  always_comb begin
    special_s = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
    if ((bus.divisor == ZERO_W) || ((bus.dividend == MIN_W) && (bus.divisor == ONES_W))) begin
      special_s = 1'b1;
    end else begin
      special_s = 1'b0;
    end
`else
    if (bus.divisor == ZERO_W) begin
      special_s = 1'b1;
    end else begin
      special_s = 1'b0;
    end
`endif
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The borrow bit of the WIDTH+1-bit difference doubles as the compare.
  always_comb begin
    r_shift_s = {rem_r, q_r[WIDTH-1]};
    r_diff_s  = r_shift_s - {1'b0, div_r};
    r_ge_s    = ~r_diff_s[WIDTH];
    if (r_ge_s) begin
      r_next_s = r_diff_s[WIDTH-1:0];
    end else begin
      r_next_s = r_shift_s[WIDTH-1:0];
    end
    q_next_s = {q_r[WIDTH-2:0], r_ge_s};
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (special_s) begin
            state_next_s = FIN;
          end else begin
            state_next_s = RUN;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_ZERO) begin
`ifdef SEQ_DIV_SIGNED_EN
          state_next_s = SIGN;
`else
          state_next_s = FIN;
`endif
        end else begin
          state_next_s = RUN;
        end
      end
`ifdef SEQ_DIV_SIGNED_EN
      SIGN:    state_next_s = FIN;
`endif
      FIN:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == FIN);
    end
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r       <= ZERO_W;
      q_r         <= ZERO_W;
      div_r       <= ZERO_W;
      cnt_r       <= CNT_ZERO;
      quotient_r  <= ZERO_W;
      remainder_r <= ZERO_W;
      overflow_r  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            rem_r <= ZERO_W;
            cnt_r <= CNT_LAST;
`ifdef SEQ_DIV_SIGNED_EN
            q_r     <= mag(bus.dividend);
            div_r   <= mag(bus.divisor);
            neg_q_r <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r_r <= bus.dividend[WIDTH-1];
`else
            q_r     <= bus.dividend;
            div_r   <= bus.divisor;
`endif
            if (bus.divisor == ZERO_W) begin
              quotient_r  <= ONES_W;
              remainder_r <= bus.dividend;
              overflow_r  <= 1'b1;
            end else if (special_s) begin
              // Only reachable with the signed option: MIN / -1.
              quotient_r  <= bus.dividend;
              remainder_r <= ZERO_W;
              overflow_r  <= 1'b1;
            end else begin
              overflow_r  <= 1'b0;
            end
          end
        end
        RUN: begin
          rem_r <= r_next_s;
          q_r   <= q_next_s;
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
`ifndef SEQ_DIV_SIGNED_EN
            quotient_r  <= q_next_s;
            remainder_r <= r_next_s;
`endif
          end
        end
`ifdef SEQ_DIV_SIGNED_EN
        SIGN: begin
          // Truncation toward zero: remainder takes the dividend's sign.
          quotient_r  <= neg_q_r ? -q_r : q_r;
          remainder_r <= neg_r_r ? -rem_r : rem_r;
        end
`endif
        default: begin
          rem_r <= rem_r;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: table-driven directed bench for seq_div at WIDTH=16, with
// hand-written sequences for ignored starts, start during FIN, and reset
// mid-run. Expected values hold for both builds (SEQ_DIV_SIGNED_EN or not).
module tb_seq_div;

  localparam int W = 16;
`ifdef SEQ_DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic clk;
  logic reset;
  int   errs;
  int   checks;

  seq_div_if #(.WIDTH(W)) bus ();

  seq_div #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         eov;
    int           elat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one division; p1/p2 (>0) are cycles at which a stray start with
  // other operands is pulsed and must be ignored.
  task automatic run_div(input string nm, input vec_t v, input int p1, input int p2);
    int   lat;
    bit   seen;
    bit   busy_ok;
    bit   hold_ok;
    @(negedge clk);
    bus.dividend = v.a;
    bus.divisor  = v.b;
    bus.start    = 1'b1;
    @(posedge clk);
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == p1 || lat == p2) begin
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (lat == 1 && !v.eov) chk({nm, " ovf_clear"}, 64'(bus.overflow), 64'd0);
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'(v.elat));
    chk({nm, " quotient"}, 64'(bus.quotient), 64'(v.eq));
    chk({nm, " remainder"}, 64'(bus.remainder), 64'(v.er));
    chk({nm, " overflow"}, 64'(bus.overflow), 64'(v.eov));
    chk({nm, " busy_thru"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    chk({nm, " done_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.quotient !== v.eq || bus.remainder !== v.er || bus.overflow !== v.eov) hold_ok = 1'b0;
    end
    chk({nm, " hold"}, 64'(hold_ok), 64'd1);
  endtask

  initial begin
    vec_t vt[9];
    vec_t v;
    int   n;
    bit   seen;
    errs = 0; checks = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.dividend = 16'd0; bus.divisor = 16'd0;

    vt[0] = '{16'd100,   16'd7,    16'd14,   16'd2,    1'b0, LAT};
    vt[1] = '{16'hFFFF,  16'd1,    16'hFFFF, 16'd0,    1'b0, LAT};
    vt[2] = '{16'd5,     16'd9,    16'd0,    16'd5,    1'b0, LAT};
    vt[3] = '{16'd1234,  16'd0,    16'hFFFF, 16'd1234, 1'b1, 1};
    vt[4] = '{16'd50,    16'd5,    16'd10,   16'd0,    1'b0, LAT};
    vt[5] = '{16'd1000,  16'd1000, 16'd1,    16'd0,    1'b0, LAT};
    vt[6] = '{16'd0,     16'd3,    16'd0,    16'd0,    1'b0, LAT};
`ifdef SEQ_DIV_SIGNED_EN
    vt[7] = '{16'hFFF9,  16'd2,    16'hFFFD, 16'hFFFF, 1'b0, LAT};
    vt[8] = '{16'h8000,  16'hFFFF, 16'h8000, 16'd0,    1'b1, 1};
`else
    vt[7] = '{16'hFFF9,  16'd2,    16'h7FFC, 16'd1,    1'b0, LAT};
    vt[8] = '{16'h8000,  16'hFFFF, 16'd0,    16'h8000, 1'b0, LAT};
`endif

    repeat (3) @(negedge clk);
    chk("reset_state", 64'({bus.busy, bus.done, bus.overflow, bus.quotient, bus.remainder}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'({bus.busy, bus.done}), 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_div($sformatf("vec%0d", i), vt[i], 0, 0);
    end

    // Stray starts at cycles 3 and 10 of a run must not disturb it.
    run_div("ignore_start", vt[0], 3, 10);

    // start high during the FIN/done cycle is ignored.
    @(negedge clk);
    bus.dividend = 16'd100; bus.divisor = 16'd7; bus.start = 1'b1;
    @(posedge clk);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    chk("fin_seen", 64'(seen), 64'd1);
    bus.dividend = 16'd50; bus.divisor = 16'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("fin_start_ignored", 64'({bus.busy, bus.quotient}), 64'({1'b0, 16'd14}));
    @(negedge clk);
    chk("fin_start_stays_idle", 64'(bus.busy), 64'd0);

    // Reset mid-run at cycle 8 clears everything immediately.
    bus.dividend = 16'd100; bus.divisor = 16'd7; bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("busy_before_reset", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("reset_mid_run", 64'({bus.busy, bus.done, bus.overflow, bus.quotient, bus.remainder}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_mid_reset", 64'(bus.busy), 64'd0);
    v = '{16'd50, 16'd5, 16'd10, 16'd0, 1'b0, LAT};
    run_div("after_reset", v, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
